uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter: the next-generation serial TX engine for the uart_loop system. It serialises parallel words onto a single line with configurable clock/baud ratio, data width, parity and stop-bit count, using a valid/ready handshake instead of a single-cycle strobe. An optional input FIFO decouples bursty producers, such as the loopback receiver, from the line rate.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz
- BAUD_RATE, 9600: line rate in baud
- DATA_BITS, 8: payload bits per frame, legal 5..8
- PARITY_MODE, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: stop bits, legal 1 or 2
- FIFO_DEPTH, 16: input FIFO entries, power of two ≥ 2; used only with UART_TX_FIFO_EN
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-low reset
- trans_data  in  DATA_BITS  word to send, LSB first
- trans_valid  in  1  producer has a word
- trans_ready  out  1  block accepts a word this cycle
- tx_data  out  1  serial line, idle high
- tx_busy  out  1  frame in progress on the line

## Operation
- BIT_DIV = CLK_FREQ / BAUD_RATE, integer-truncated. Every line bit lasts exactly BIT_DIV cycles. The divider counter is $clog2(BIT_DIV) bits wide and runs 0..BIT_DIV-1.
- A word transfers when trans_valid && trans_ready on a rising edge. trans_data is captured into a shift register (or the FIFO) at that edge. The producer holds data and valid until ready.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when a word is available (accepted word, or FIFO non-empty).
  - START → DATA after 1 bit time.
  - DATA → PARITY after DATA_BITS bit times when PARITY_MODE≠0, otherwise DATA → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP → IDLE after STOP_BITS bit times.
- Line levels: START drives 0; DATA drives shift-register LSB and shifts right each bit time; STOP drives 1; IDLE drives 1.
- PARITY drives the even parity bit (XOR of payload bits) for mode 2, and its inverse for mode 1. Parity is computed from the captured word, not from live trans_data.
- tx_busy = (state ≠ IDLE).
- Illegal parameter values are rejected by elaboration-time checks, not by runtime behaviour.

## Timing
- Reset values: tx_data=1, tx_busy=0, trans_ready=0 while sys_rst low; FSM=IDLE, counters=0, FIFO empty.
- Reset asserted mid-frame: tx_data returns to 1 immediately (async). The partial frame and all FIFO contents are discarded.
- tx_data is registered. The start-bit falling edge appears on the first edge after the word is taken into the FSM.
- Without FIFO, trans_ready = (state==IDLE) && sys_rst deasserted.
  - Acceptance edge → tx_data=0 on the next cycle.
  - Frame length = BIT_DIV × (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) cycles.
  - One IDLE cycle separates back-to-back frames, so the accept-to-accept spacing is frame length + 1.
- trans_data changes while ready is low have no effect.
- Simultaneous events:
  - Without FIFO, the acceptance in IDLE and the FSM leaving IDLE occur on the same edge.
  - With FIFO, a push and a pop on the same edge keep the count unchanged.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO sits in front of the FSM.
  - trans_ready = !full.
  - The FSM pops one entry on leaving IDLE.
  - A write into an empty FIFO reaches tx_data as a start bit 2 cycles after acceptance.
  - A full FIFO holds ready low and loses no data.
- UART_TX_FIFO_EN undefined: no FIFO, single-word handshake as in Timing. FIFO_DEPTH is ignored.

## Structure
- A shared package, uart_pkg, holds:
  - the PARITY_MODE encodings (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the FSM state enum;
  - a function computing BIT_DIV, reused by the matching receiver.
- One sub-module, uart_tx_fifo: synchronous single-clock FIFO with full/empty flags and a power-of-two depth using wrap-around pointers plus an extra MSB. It is instantiated only under UART_TX_FIFO_EN.

## Test plan
- CLK_FREQ=50_000_000, BAUD_RATE=115200 (BIT_DIV=434), 8N1, send 0x55 → tx_data 0,1,0,1,0,1,0,1,0,1, each held exactly 434 cycles; tx_busy high for 4340 cycles; trans_ready low throughout.
- 8E1, send 0x07 → parity bit 1. 8O1, send 0x07 → parity bit 0. 8E1, send 0x00 → parity bit 0.
- DATA_BITS=7, STOP_BITS=2, no parity, send 0x41 → 1 start, 7 data bits 1,0,0,0,0,0,1, 2 stop bits; frame = 10×BIT_DIV cycles.
- No FIFO, trans_valid held high with 3 words → accepts spaced by frame length + 1 cycles; line shows exactly one idle-high cycle between frames.
- UART_TX_FIFO_EN, FIFO_DEPTH=4, push 6 words continuously → ready drops after 5 accepts (4 stored + 1 in FSM); all 6 bytes appear on the line in order.
- Assert sys_rst mid-data-bit of a frame → tx_data=1 within the same cycle, tx_busy=0. After release, the next word sends a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and the
// clock-to-baud divider helper (also used by the matching receiver).
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned bit_div(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock power-of-two FIFO; pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] trans_data,
  input  logic                 trans_valid,
  output logic                 trans_ready,
  output logic                 tx_data,
  output logic                 tx_busy
);

  localparam int unsigned BIT_DIV = bit_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW      = $clog2(BIT_DIV);
  localparam int unsigned BW      = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY_MODE > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (BIT_DIV < 2) begin : g_bad_bit_div
    $error("uart_tx_param: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t            state;
  tx_state_t            next_state;
  logic [CW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic                 par_bit;
  logic                 line_next;
  logic                 bit_end;
  logic                 word_avail;
  logic                 take;
  logic [DATA_BITS-1:0] word;

  assign bit_end = (div_cnt == CW'(BIT_DIV - 1));
  assign take    = (state == IDLE) && word_avail;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .push    (trans_valid && trans_ready),
    .pop     (take),
    .wr_data (trans_data),
    .rd_data (word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign trans_ready = sys_rst && !fifo_full;
  assign word_avail  = !fifo_empty;
`else
  assign trans_ready = sys_rst && (state == IDLE);
  assign word_avail  = trans_valid;
  assign word        = trans_data;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (take) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && bit_cnt == BW'(DATA_BITS - 1))
                 next_state = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end && bit_cnt == BW'(STOP_BITS - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The line level is computed from the next state so the registered tx_data
  // lines up with the state it belongs to.
  always_comb begin
    tx_busy = (state != IDLE);
    unique case (next_state)
      START:   line_next = 1'b0;
      DATA:    line_next = shreg_next[0];
      PARITY:  line_next = par_bit;
      default: line_next = 1'b1;
    endcase
  end

  always_comb begin
    shreg_next = shreg;
    if (take)                          shreg_next = word;
    else if (state == DATA && bit_end) shreg_next = shreg >> 1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_data <= 1'b1;
    end else begin
      div_cnt <= (state == IDLE || bit_end) ? '0 : div_cnt + 1'b1;
      if (state != next_state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;
      shreg   <= shreg_next;
      if (take) par_bit <= (^word) ^ (PARITY_MODE == PAR_ODD);
      tx_data <= line_next;
    end
  end

endmodule
